retro_sram_timed: RTL

Parametrised successor to the team's pass-through SRAM controller. Adds programmable read/write wait states, write setup/hold phases and read-to-next-access bus turnaround. Adds multi-beat width adaptation: a wide initiator word maps to several narrow SRAM beats. Adds one-hot chip select decoded from the address MSBs. Sits between a single-port memory initiator (CPU/PPU bus arbiter) and external asynchronous SRAM pins.

---
 rtl/retro_sram_timed_if.sv | 31 +++
 rtl/retro_sram_timed.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/retro_sram_timed_if.sv
// Initiator-side request/response bus of the timed SRAM controller.
//   Access    : request strobe, held by the initiator until accepted
//   Write     : 1 = write, 0 = read, sampled together with Access
//   Address   : word address, chip-select bits in the MSBs
//   Din       : write data
//   Dout      : read data, holds the last completed read
//   Ready     : controller accepts a request this cycle
//   DataReady : one-cycle completion pulse
// master = initiator side, slave = controller side.
interface retro_sram_timed_if #(
    parameter int unsigned AddressBusWidth = 16,
    parameter int unsigned DataBusWidth    = 16
);
    logic                       Access;
    logic                       Write;
    logic [AddressBusWidth-1:0] Address;
    logic [DataBusWidth-1:0]    Din;
    logic [DataBusWidth-1:0]    Dout;
    logic                       Ready;
    logic                       DataReady;

    modport master (
        output Access, Write, Address, Din,
        input  Dout, Ready, DataReady
    );

    modport slave (
        input  Access, Write, Address, Din,
        output Dout, Ready, DataReady
    );
endinterface

// File: rtl/retro_sram_timed.sv
// Timed controller between a single-port initiator and external async SRAM.
// A wide initiator word is split into Beats narrow SRAM beats (LS slice
// first); reads and writes get programmable wait states, writes get setup
// and hold phases, and reads are followed by a bus turnaround gap.
// Ports:
//   Clk, Reset   : clock, synchronous active-high reset
//   bus          : initiator bus (slave modport)
//   SramAddress  : {word address without chip bits, beat index}
//   SramCE_n     : one-hot active-low chip enables from the address MSBs
//   SramOE_n     : active-low output enable
//   SramWE_n     : active-low write enable
//   SramDout     : write data towards the pins
//   SramDrive    : 1 = controller drives the data pins
//   SramDin      : data from the pins
// Every output is registered; outputs are computed from the next state.
module retro_sram_timed #(
    parameter int unsigned AddressBusWidth  = 16,
    parameter int unsigned DataBusWidth     = 16,
    parameter int unsigned SramDataWidth    = 8,
    parameter int unsigned ChipCount        = 2,
    parameter int unsigned ReadWaitStates   = 1,
    parameter int unsigned WriteWaitStates  = 1,
    parameter int unsigned TurnaroundCycles = 1,
    localparam int unsigned Beats         = DataBusWidth / SramDataWidth,
    localparam int unsigned CsBits        = $clog2(ChipCount),
    localparam int unsigned BeatBits      = $clog2(Beats),
    localparam int unsigned SramAddrWidth = AddressBusWidth - CsBits + BeatBits
) (
    input  logic                     Clk,
    input  logic                     Reset,
    retro_sram_timed_if.slave        bus,
    output logic [SramAddrWidth-1:0] SramAddress,
    output logic [ChipCount-1:0]     SramCE_n,
    output logic                     SramOE_n,
    output logic                     SramWE_n,
    output logic [SramDataWidth-1:0] SramDout,
    output logic                     SramDrive,
    input  logic [SramDataWidth-1:0] SramDin
);

    localparam int unsigned LowAddrWidth = AddressBusWidth - CsBits;
    localparam int unsigned BeatCntWidth = (BeatBits > 0) ? BeatBits : 1;
    localparam int unsigned ChipIdxWidth = (CsBits > 0) ? CsBits : 1;
    localparam int unsigned TurnLoad     = (TurnaroundCycles > 0) ? TurnaroundCycles - 1 : 0;
    localparam int unsigned WaitMaxRw    = (ReadWaitStates > WriteWaitStates) ? ReadWaitStates
                                                                              : WriteWaitStates;
    localparam int unsigned WaitMax      = (WaitMaxRw > TurnLoad) ? WaitMaxRw : TurnLoad;
    localparam int unsigned WaitWidth    = ($clog2(WaitMax + 1) > 0) ? $clog2(WaitMax + 1) : 1;
    localparam logic [BeatCntWidth-1:0] LastBeat = BeatCntWidth'(Beats - 1);
    localparam logic [DataBusWidth-1:0] SliceMask = DataBusWidth'({SramDataWidth{1'b1}});

    typedef enum logic [2:0] {
        IDLE,
        RD_BEAT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE,
        TURN
    } state_t;

    state_t                    state_q, state_d;
    logic [BeatCntWidth-1:0]   beat_q, beat_d;
    logic [WaitWidth-1:0]      wait_q, wait_d;
    logic [LowAddrWidth-1:0]   addr_low_q, addr_low_d;
    logic [ChipIdxWidth-1:0]   chip_q, chip_d;
    logic                      write_q, write_d;
    logic [DataBusWidth-1:0]   din_q, din_d;
    logic [DataBusWidth-1:0]   rd_buf_q, rd_buf_d;
    logic [DataBusWidth-1:0]   dout_q, dout_d;
    logic                      data_ready_q, data_ready_d;
    logic                      ready_q, ready_d;
    logic [SramAddrWidth-1:0]  sram_addr_q, sram_addr_d;
    logic [ChipCount-1:0]      ce_n_q, ce_n_d;
    logic                      oe_n_q, oe_n_d;
    logic                      we_n_q, we_n_d;
    logic [SramDataWidth-1:0]  sram_dout_q, sram_dout_d;
    logic                      drive_q, drive_d;

    // State, counters, latched request and registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            wait_q       <= '0;
            addr_low_q   <= '0;
            chip_q       <= '0;
            write_q      <= 1'b0;
            din_q        <= '0;
            rd_buf_q     <= '0;
            dout_q       <= '0;
            data_ready_q <= 1'b0;
            ready_q      <= 1'b0;
            sram_addr_q  <= '0;
            ce_n_q       <= '1;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            sram_dout_q  <= '0;
            drive_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            wait_q       <= wait_d;
            addr_low_q   <= addr_low_d;
            chip_q       <= chip_d;
            write_q      <= write_d;
            din_q        <= din_d;
            rd_buf_q     <= rd_buf_d;
            dout_q       <= dout_d;
            data_ready_q <= data_ready_d;
            ready_q      <= ready_d;
            sram_addr_q  <= sram_addr_d;
            ce_n_q       <= ce_n_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            sram_dout_q  <= sram_dout_d;
            drive_q      <= drive_d;
        end
    end

    // Next state, then pin values derived from the next state so that the
    // registered pins line up with the phase they belong to.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        wait_d       = wait_q;
        addr_low_d   = addr_low_q;
        chip_d       = chip_q;
        write_d      = write_q;
        din_d        = din_q;
        rd_buf_d     = rd_buf_q;
        dout_d       = dout_q;
        data_ready_d = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_dout_d  = sram_dout_q;
        ce_n_d       = '1;
        oe_n_d       = 1'b1;
        we_n_d       = 1'b1;
        drive_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Access && ready_q) begin
                    addr_low_d = LowAddrWidth'(bus.Address);
                    chip_d     = ChipIdxWidth'(bus.Address >> LowAddrWidth);
                    write_d    = bus.Write;
                    din_d      = bus.Din;
                    beat_d     = '0;
                    if (bus.Write) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD_BEAT;
                        wait_d  = WaitWidth'(ReadWaitStates);
                    end
                end
            end
            RD_BEAT: begin
                if (wait_q == '0) begin
                    // Last edge of the beat: capture this slice.
                    rd_buf_d = (rd_buf_q & ~(SliceMask << (32'(beat_q) * SramDataWidth)))
                             | (DataBusWidth'(SramDin) << (32'(beat_q) * SramDataWidth));
                    if (beat_q == LastBeat) begin
                        state_d      = DONE;
                        data_ready_d = 1'b1;
                        dout_d       = rd_buf_d;
                    end else begin
                        beat_d = beat_q + 1'b1;
                        wait_d = WaitWidth'(ReadWaitStates);
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            WR_SETUP: begin
                state_d = WR_PULSE;
                wait_d  = WaitWidth'(WriteWaitStates);
            end
            WR_PULSE: begin
                if (wait_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            WR_HOLD: begin
                if (beat_q == LastBeat) begin
                    state_d      = DONE;
                    data_ready_d = 1'b1;
                end else begin
                    state_d = WR_SETUP;
                    beat_d  = beat_q + 1'b1;
                end
            end
            DONE: begin
                if (write_q || (TurnaroundCycles == 0)) begin
                    state_d = IDLE;
                end else begin
                    state_d = TURN;
                    wait_d  = WaitWidth'(TurnLoad);
                end
            end
            TURN: begin
                if (wait_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values for the phase being entered.
        case (state_d)
            RD_BEAT: begin
                ce_n_d[chip_d] = 1'b0;
                oe_n_d         = 1'b0;
                sram_addr_d    = (SramAddrWidth'(addr_low_d) << BeatBits) | SramAddrWidth'(beat_d);
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                ce_n_d[chip_d] = 1'b0;
                drive_d        = 1'b1;
                we_n_d         = (state_d != WR_PULSE);
                sram_addr_d    = (SramAddrWidth'(addr_low_d) << BeatBits) | SramAddrWidth'(beat_d);
                sram_dout_d    = SramDataWidth'(din_d >> (32'(beat_d) * SramDataWidth));
            end
            default: ;
        endcase
    end

    // Ready reflects IDLE one cycle late, so it stays low throughout reset.
    assign ready_d = (state_d == IDLE);

    assign bus.Dout      = dout_q;
    assign bus.Ready     = ready_q;
    assign bus.DataReady = data_ready_q;
    assign SramAddress   = sram_addr_q;
    assign SramCE_n      = ce_n_q;
    assign SramOE_n      = oe_n_q;
    assign SramWE_n      = we_n_q;
    assign SramDout      = sram_dout_q;
    assign SramDrive     = drive_q;

endmodule
